pll_lock_supervisor: RTL
========================

# pll_lock_supervisor

Consumer side of the board PLL: runs on the PLL output clock and turns the raw, asynchronous PLL `locked` indication into a clean, debounced, synchronous system reset. Downstream logic (ADC capture, USB/SPI readout, current-logging pipeline) is held in reset until the PLL has stayed locked continuously for a programmable time. Any loss of lock re-asserts reset for a guaranteed minimum time and is recorded in a sticky fault flag and a saturating loss counter.

## Interface
- `STABLE_CYCLES`, default 1024: consecutive synchronized-locked cycles required before release; legal ≥ 1.
- `HOLD_CYCLES`, default 16: minimum cycles `sys_reset_n` stays low after reset or lock loss; legal ≥ 2.
- `CNT_W`, default 8: width of `loss_count`.
- `clock`  in  1  PLL output clock; the only clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `locked`  in  1  raw PLL lock, asynchronous to `clock`.
- `clear_fault`  in  1  synchronous pulse; clears `lock_lost` and `loss_count`.
- `sys_reset_n`  out  1  registered system reset, active low.
- `ready`  out  1  registered; high exactly when `sys_reset_n` is high.
- `lock_lost`  out  1  sticky: lock dropped while in RUN.
- `loss_count`  out  CNT_W  number of RUN-state lock losses, saturating at all-ones.

## Operation
- `locked` passes through a 2-flop synchronizer (`s1`, `s2`); `locked_s` = `s2`. Both flops reset to 0.
- States: HOLD, WAIT_LOCK, STABLE, RUN. A single internal counter, wide enough for max(`STABLE_CYCLES`, `HOLD_CYCLES`), is cleared on each state entry.
- HOLD: counter increments every cycle; when counter == `HOLD_CYCLES`-1, go to WAIT_LOCK. `locked_s` is ignored.
- WAIT_LOCK: if `locked_s`=1, go to STABLE.
- STABLE: if `locked_s`=0, return to WAIT_LOCK. No fault is recorded, because acquisition glitches are normal. Otherwise the counter increments; when counter == `STABLE_CYCLES`-1, go to RUN.
- RUN: if `locked_s`=0, go to HOLD, set `lock_lost`=1 and increment `loss_count` unless it is all-ones.
- `sys_reset_n` and `ready` are registered from next-state == RUN, so both are high exactly in the cycles where state == RUN.
- `clear_fault` in any state clears `lock_lost` to 0 and `loss_count` to 0. If it coincides with a RUN lock loss, the loss wins: `lock_lost`=1, `loss_count`=1.
- Reset (`reset_n`=0 at an edge): state HOLD, counter 0, `s1`/`s2` 0, `sys_reset_n` 0, `ready` 0, `lock_lost` 0, `loss_count` 0. Reset applied mid-STABLE or mid-RUN aborts immediately to these values; loss history is lost.

## Timing
- Edges are numbered from the first rising edge at which `reset_n`=1 (edge 1).
- Synchronizer latency: 2 edges from a `locked` change to `locked_s`.
- Power-up with `locked` already high: WAIT_LOCK after edge `HOLD_CYCLES`; STABLE after edge `HOLD_CYCLES`+1; `sys_reset_n`/`ready` rise after edge `HOLD_CYCLES`+1+`STABLE_CYCLES`.
- Release from WAIT_LOCK: `locked` rises before edge k; STABLE after edge k+2; release after edge k+2+`STABLE_CYCLES`.
- Lock loss in RUN: `locked` falls before edge k; `sys_reset_n` low after edge k+2; `lock_lost`/`loss_count` update on the same edge.
- Hold: `sys_reset_n` then stays low for at least `HOLD_CYCLES`+1+`STABLE_CYCLES` cycles, even if `locked` returns immediately.
- Glitch filtering: a `locked` pulse shorter than 1 cycle may be missed entirely; this is acceptable. A low pulse ≥ 2 cycles wide in RUN is always detected.

## Test plan
- Power-up, `HOLD_CYCLES`=4, `STABLE_CYCLES`=4, `locked`=1 throughout -> `sys_reset_n`/`ready` 0 through edge 8, 1 after edge 9; `lock_lost`=0, `loss_count`=0.
- `locked`=0 at power-up, rises before edge 20 (same parameters) -> release after edge 26; no fault recorded.
- In STABLE, drop `locked` for 3 cycles after 2 locked cycles -> back to WAIT_LOCK; counter restarts; release delayed accordingly; `lock_lost`=0.
- In RUN, drop `locked` before edge k for 1 cycle -> `sys_reset_n`=0 after edge k+2, `lock_lost`=1, `loss_count`=1; re-release exactly `HOLD_CYCLES`+1+`STABLE_CYCLES` edges later.
- `CNT_W`=2, force 5 RUN losses -> `loss_count` reads 1, 2, 3, 3, 3; `clear_fault` on the same edge as a 6th loss -> `loss_count`=1, `lock_lost`=1.
- Assert `reset_n`=0 for 1 cycle while in RUN with `loss_count`=2 -> all outputs 0 next cycle; full power-up sequence repeats.

Source files
------------

// File: rtl/pll_lock_supervisor_if.sv
// Status/control bundle between the PLL lock supervisor and its consumer.
// The consumer side drives the raw lock and fault clear; the supervisor drives reset and fault status.
interface pll_lock_supervisor_if #(
    parameter int unsigned CNT_W = 8
);
    logic             locked;
    logic             clear_fault;
    logic             sys_reset_n;
    logic             ready;
    logic             lock_lost;
    logic [CNT_W-1:0] loss_count;

    modport master (
        output locked,
        output clear_fault,
        input  sys_reset_n,
        input  ready,
        input  lock_lost,
        input  loss_count
    );

    modport slave (
        input  locked,
        input  clear_fault,
        output sys_reset_n,
        output ready,
        output lock_lost,
        output loss_count
    );
endinterface

// File: rtl/pll_lock_supervisor.sv
// Turns the asynchronous PLL lock into a debounced synchronous system reset,
// with a minimum hold time after any loss and sticky loss accounting.
module pll_lock_supervisor #(
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned HOLD_CYCLES   = 16,
    parameter int unsigned CNT_W         = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    pll_lock_supervisor_if.slave  bus
);
    localparam int unsigned MAX_CYC = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
    localparam int unsigned CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic [1:0] {
        HOLD      = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             s1;
    logic             s2;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic             run_loss;
    logic             sys_nxt;
    logic             lost_nxt;
    logic [CNT_W-1:0] count_nxt;

    // Two-flop synchronizer for the raw lock indication
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= bus.locked;
            s2 <= s1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= HOLD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            HOLD:      if (cnt == CW'(HOLD_CYCLES - 1)) state_nxt = WAIT_LOCK;
            WAIT_LOCK: if (s2) state_nxt = STABLE;
            STABLE: begin
                if (!s2) begin
                    state_nxt = WAIT_LOCK;
                end else if (cnt == CW'(STABLE_CYCLES - 1)) begin
                    state_nxt = RUN;
                end
            end
            RUN:       if (!s2) state_nxt = HOLD;
            default:   state_nxt = HOLD;
        endcase
    end

    // Next values for the registered outputs and the shared dwell counter
    always_comb begin
        cnt_nxt   = cnt;
        run_loss  = (state == RUN) && !s2;
        sys_nxt   = (state_nxt == RUN);
        lost_nxt  = bus.lock_lost;
        count_nxt = bus.loss_count;
        if (state_nxt != state) begin
            cnt_nxt = '0;
        end else if (state == HOLD || state == STABLE) begin
            cnt_nxt = cnt + CW'(1);
        end
        if (bus.clear_fault) begin
            lost_nxt  = 1'b0;
            count_nxt = '0;
        end
        // A loss on the same edge as a clear must still be recorded
        if (run_loss) begin
            lost_nxt = 1'b1;
            if (bus.clear_fault) begin
                count_nxt = CNT_W'(1);
            end else if (bus.loss_count != {CNT_W{1'b1}}) begin
                count_nxt = bus.loss_count + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt             <= '0;
            bus.sys_reset_n <= 1'b0;
            bus.ready       <= 1'b0;
            bus.lock_lost   <= 1'b0;
            bus.loss_count  <= '0;
        end else begin
            cnt             <= cnt_nxt;
            bus.sys_reset_n <= sys_nxt;
            bus.ready       <= sys_nxt;
            bus.lock_lost   <= lost_nxt;
            bus.loss_count  <= count_nxt;
        end
    end
endmodule
